// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes and FSM encoding for the load/store unit
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and access legality checks
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shift;

  // Read word shifted so the addressed byte sits in lane 0.
  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  // Byte enables and replicated store data depend only on the access size bits.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Sign- or zero-extend the selected load bytes.
  always_comb begin
    o_load = w_shift;
    case (i_funct3)
      F3_B:    o_load = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   o_load = {24'd0, w_shift[7:0]};
      F3_H:    o_load = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   o_load = {16'd0, w_shift[15:0]};
      default: o_load = w_shift;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment; stores only allow b/h/w.
  always_comb begin
    o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    if (i_is_store)
      o_illegal = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
    else
      o_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with stall, fault and timeout handling
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        fault,
  output logic [31:0] fault_addr
);

  lsu_state_t  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_sdata, r_cnt;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data, r_fault_addr;
  logic [4:0]  r_wb_rd;
  logic        r_fault;

  logic        w_idle, w_busy, w_req, w_bad, w_accept, w_reject, w_timeout;
  logic [2:0]  w_f3;
  logic [1:0]  w_lo;
  logic [31:0] w_sd, w_wdata, w_load;
  logic        w_is_store, w_mis, w_ill;
  logic [3:0]  w_be;

  assign w_idle = (r_state == ST_IDLE);
  assign w_busy = (r_state == ST_BUSY);

  // The aligner sees live inputs while idle (legality check) and captured values afterwards.
  assign w_f3       = w_idle ? funct3     : r_f3;
  assign w_lo       = w_idle ? addr[1:0]  : r_addr[1:0];
  assign w_sd       = w_idle ? store_data : r_sdata;
  assign w_is_store = w_idle ? mem_write  : r_we;

  lsu_align u_align (
    .i_funct3     (w_f3),
    .i_addr_lo    (w_lo),
    .i_is_store   (w_is_store),
    .i_store_data (w_sd),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load       (w_load),
    .o_misaligned (w_mis),
    .o_illegal    (w_ill)
  );

  assign w_req     = ex_valid && (mem_read || mem_write);
  assign w_bad     = (mem_read && mem_write) || w_ill || w_mis;
  assign w_accept  = w_idle && w_req && !w_bad;
  assign w_reject  = w_idle && w_req && w_bad;
  assign w_timeout = w_busy && !mem_ready && (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; request fields are driven only while busy.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    done      = 1'b0;
    wb_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = ST_BUSY;
      end
      ST_BUSY: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_be    = w_be;
        mem_wdata = w_wdata;
        if (mem_ready)      w_next = ST_RESP;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_RESP: begin
        done     = 1'b1;
        wb_valid = !r_we;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request, run the wait counter, latch load results and fault pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_addr       <= 32'd0;
      r_sdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_cnt        <= 32'd0;
      r_wb_data    <= 32'd0;
      r_wb_rd      <= 5'd0;
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else begin
      r_fault <= w_reject || w_timeout;
      if (w_reject)       r_fault_addr <= addr;
      else if (w_timeout) r_fault_addr <= r_addr;
      if (w_accept) begin
        r_we    <= mem_write;
        r_f3    <= funct3;
        r_addr  <= addr;
        r_sdata <= store_data;
        r_rd    <= rd_in;
        r_cnt   <= 32'd0;
      end else if (w_busy && !mem_ready) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_busy && mem_ready && !r_we) begin
        r_wb_data <= w_load;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign wb_data    = r_wb_data;
  assign wb_rd      = r_wb_rd;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk, reset;
  logic        ex_valid, ex_valid_t, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic [4:0]  rd_in;
  logic        mem_ready, mem_ready_t;

  logic        stall, mem_req, mem_we, done, wb_valid, fault;
  logic [31:0] mem_addr, mem_wdata, wb_data, fault_addr;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  logic        t_stall, t_mem_req, t_mem_we, t_done, t_wb_valid, t_fault;
  logic [31:0] t_mem_addr, t_mem_wdata, t_wb_data, t_fault_addr;
  logic [3:0]  t_mem_be;
  logic [4:0]  t_wb_rd;

  int n_checks = 0;
  int n_err    = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .done(done), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .fault(fault), .fault_addr(fault_addr)
  );

  load_store_unit #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .ex_valid(ex_valid_t), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .stall(t_stall), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
    .mem_wdata(t_mem_wdata), .mem_ready(mem_ready_t), .mem_rdata(mem_rdata),
    .done(t_done), .wb_valid(t_wb_valid), .wb_data(t_wb_data), .wb_rd(t_wb_rd),
    .fault(t_fault), .fault_addr(t_fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One legal access; mem_ready arrives after 'waits' busy cycles. Ends in the IDLE cycle after RESP.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        output int stalls, output logic [31:0] wbd);
    ex_valid = 1'b1; mem_read = !we; mem_write = we; funct3 = f3; addr = a;
    store_data = sd; rd_in = rd; mem_ready = 1'b0;
    stalls = 0;
    #1;
    if (stall) stalls++;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b111;
    addr = 32'hDEAD_BEEF; store_data = ~sd; rd_in = 5'd0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      #1;
      if (stall) stalls++;
      check("busy_mem_req", mem_req, 1);
      check("busy_mem_addr", mem_addr, {a[31:2], 2'b00});
      check("busy_mem_be", mem_be, exp_be);
      check("busy_mem_we", mem_we, we);
      if (we) check("busy_mem_wdata", mem_wdata, exp_wd);
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    #1;
    check("resp_done", done, 1);
    check("resp_wb_valid", wb_valid, !we);
    check("resp_stall", stall, 0);
    check("resp_mem_req", mem_req, 0);
    if (!we) check("resp_wb_rd", wb_rd, rd);
    wbd = wb_data;
    tick();
    check("idle_done", done, 0);
    check("idle_wb_valid", wb_valid, 0);
  endtask

  // An illegal or misaligned request: fault pulse next cycle and no memory activity.
  task automatic reject(input logic rd_op, input logic wr_op, input logic [2:0] f3, input logic [31:0] a);
    ex_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3; addr = a;
    #1;
    check("rej_stall", stall, 0);
    check("rej_mem_req", mem_req, 0);
    tick();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0;
    #1;
    check("rej_fault", fault, 1);
    check("rej_fault_addr", fault_addr, a);
    check("rej_mem_req_after", mem_req, 0);
    check("rej_stall_after", stall, 0);
    tick();
    check("rej_fault_clear", fault, 0);
    check("rej_mem_req_later", mem_req, 0);
  endtask

  int          st;
  logic [31:0] wbd;

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_valid_t = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0; rd_in = 5'd0;
    mem_ready = 1'b0; mem_ready_t = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_addr", mem_addr, 0);

    // ex_valid low: nothing happens even with an op requested.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    #1;
    check("noval_stall", stall, 0);
    tick();
    check("noval_mem_req", mem_req, 0);
    mem_read = 1'b0;

    // sb with immediate ready
    access(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd3, 32'h0, 0, 4'b1000, 32'hDDDD_DDDD, st, wbd);
    check("sb_stalls", st, 2);
    // sh upper half
    access(1'b1, 3'b001, 32'h0000_1002, 32'h1234_5678, 5'd3, 32'h0, 1, 4'b1100, 32'h5678_5678, st, wbd);
    check("sh_stalls", st, 3);

    // byte/halfword loads from one word
    access(1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd7, 32'h1180_7F22, 0, 4'b0100, 32'h0, st, wbd);
    check("lb_data", wbd, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd9, 32'h1180_7F22, 0, 4'b0100, 32'h0, st, wbd);
    check("lbu_data", wbd, 32'h0000_0080);
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd12, 32'h1180_7F22, 0, 4'b1100, 32'h0, st, wbd);
    check("lhu_data", wbd, 32'h0000_1180);
    check("lhu_hold_wb_rd", wb_rd, 12);
    access(1'b0, 3'b001, 32'h0000_2000, 32'h0, 5'd13, 32'h1180_9F22, 0, 4'b0011, 32'h0, st, wbd);
    check("lh_data", wbd, 32'hFFFF_9F22);

    // lw with ready five cycles after the request
    access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd31, 32'h8765_4321, 4, 4'b1111, 32'h0, st, wbd);
    check("lw_stalls", st, 6);
    check("lw_data", wbd, 32'h8765_4321);
    check("lw_hold_wb_data", wb_data, 32'h8765_4321);

    // faults
    reject(1'b1, 1'b0, 3'b001, 32'h0000_4001);
    reject(1'b0, 1'b1, 3'b010, 32'h0000_4002);
    reject(1'b1, 1'b0, 3'b011, 32'h0000_4000);
    reject(1'b0, 1'b1, 3'b100, 32'h0000_4004);
    reject(1'b1, 1'b1, 3'b010, 32'h0000_4008);

    // timeout on the TIMEOUT=4 instance
    ex_valid_t = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    #1;
    check("to_stall_req", t_stall, 1);
    tick();
    ex_valid_t = 1'b0; mem_read = 1'b0; addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_busy_mem_req", t_mem_req, 1);
      check("to_busy_done", t_done, 0);
      check("to_busy_fault", t_fault, 0);
      tick();
    end
    #1;
    check("to_fault", t_fault, 1);
    check("to_fault_addr", t_fault_addr, 32'h0000_5000);
    check("to_mem_req", t_mem_req, 0);
    check("to_done", t_done, 0);
    check("to_stall", t_stall, 0);
    tick();
    check("to_fault_clear", t_fault, 0);
    check("to_done_later", t_done, 0);

    // reset while busy abandons the access
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000; rd_in = 5'd5;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    #1;
    check("rb_mem_req", mem_req, 1);
    reset = 1'b1;
    tick();
    check("rb_mem_req_after", mem_req, 0);
    check("rb_stall_after", stall, 0);
    check("rb_done_after", done, 0);
    reset = 1'b0;
    tick();
    check("rb_done_idle", done, 0);
    access(1'b0, 3'b010, 32'h0000_6004, 32'h0, 5'd6, 32'hCAFE_BABE, 1, 4'b1111, 32'h0, st, wbd);
    check("rb_reload_data", wbd, 32'hCAFE_BABE);
    check("rb_reload_rd", wb_rd, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block downstream of the execute ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3 from decode.
- Drives a single-port, word-addressed data-memory handshake with byte enables.
- Returns sign- or zero-extended load data to writeback, and stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 256, max cycles to wait for mem_ready before faulting; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- ex_valid  input  1  execute-stage instruction valid.
- mem_read  input  1  load instruction.
- mem_write  input  1  store instruction.
- funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- addr  input  32  effective address (ALU out).
- store_data  input  32  rs2 value.
- rd_in  input  5  load destination register.
- stall  output  1  hold upstream stages.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  memory accepted write / returned read data.
- mem_rdata  input  32  read word.
- done  output  1  one-cycle pulse, access complete.
- wb_valid  output  1  one-cycle pulse, load result valid.
- wb_data  output  32  extended load result.
- wb_rd  output  5  destination register of wb_data.
- fault  output  1  one-cycle pulse: misaligned, illegal funct3/op, or timeout.
- fault_addr  output  32  address that faulted.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction abandons it; mem_req is low from the next cycle.
- FSM states: IDLE, BUSY, RESP.
- IDLE, request (ex_valid & (mem_read|mem_write)):
  - legal and aligned -> capture addr, funct3, data, rd, op; go BUSY.
  - illegal or misaligned -> fault=1 and fault_addr=addr next cycle; no memory access; stay IDLE.
- Illegal cases:
  - mem_read & mem_write both set.
  - load funct3 in {011, 110, 111}.
  - store funct3 not in {000, 001, 010}.
- Misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0.
- BUSY:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata held stable from captured values.
  - mem_ready=1 -> latch the extended load result; go RESP.
  - mem_ready may arrive in the first BUSY cycle (minimum 1 wait).
- RESP: done=1, and for loads wb_valid=1 with wb_data/wb_rd; return to IDLE. mem_req=0.
- Stall:
  - stall = (state==BUSY) | (IDLE & legal aligned request).
  - Low in RESP, so the next instruction advances in the same cycle the result is presented.
  - A request arriving in RESP is not sampled; upstream presents it again in the following IDLE cycle.
  - Minimum total latency: request cycle -> done 2 cycles later.
- Byte enables:
  - b: 4'b0001<<addr[1:0].
  - h: 4'b0011<<addr[1:0].
  - w: 4'b1111.
  - Loads use the same mask; memory may ignore it.
- Store data: b -> {4{store_data[7:0]}}; h -> {2{store_data[15:0]}}; w -> store_data.
- Load extract:
  - s = mem_rdata >> (8*addr[1:0]).
  - b: sext s[7:0]; bu: zext s[7:0].
  - h: sext s[15:0]; hu: zext s[15:0].
  - w: s.
- Timeout:
  - Counter increments each BUSY cycle without mem_ready.
  - On reaching TIMEOUT: fault=1 and fault_addr=captured addr next cycle; return to IDLE; no done/wb_valid.
- wb_data/wb_rd hold their last values outside pulses; only wb_valid qualifies them.
- ex_valid=0 -> no action regardless of the other inputs.

Decomposition:
- Shared package:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encoding (2 bits).
- One natural sub-module: lsu_align, combinational.
  - From (funct3, addr[1:0], store_data, mem_rdata), produces mem_be, mem_wdata, load result, misaligned, illegal.
- The top level holds the FSM, capture registers and timeout counter.

Test Plan:
- sb addr=0x1003 data=0xAABBCCDD, mem_ready in the first BUSY cycle -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xDDDDDDDD, done 2 cycles after the request, wb_valid=0.
- lb addr=0x2002, mem_rdata=0x11807F22 -> wb_data=0xFFFFFF80; repeat as lbu -> 0x00000080; lhu addr=0x2002 -> 0x00001180; wb_rd matches rd_in.
- lw addr=0x3000 with mem_ready delayed 5 cycles -> stall high for 6 cycles, request outputs stable, wb_data=mem_rdata exactly.
- lh addr=0x4001, and sw addr=0x4002 -> fault pulse with fault_addr=addr, mem_req never asserted, stall never asserted.
- TIMEOUT=4, mem_ready held low -> fault after 4 BUSY cycles, return to IDLE, no done.
- Reset asserted in BUSY -> next cycle mem_req=0, stall=0, no done; the next load completes normally.
